sysid_info_regs: RTL and testbench

SYSID_INFO_REGS -- requirements
Module: sysid_info_regs

---
 rtl/sysid_info_pkg.sv | 38 +++
 rtl/sysid_info_regs_if.sv | 41 ++++
 rtl/sysid_uptime_ctr.sv | 62 ++++++
 rtl/sysid_info_regs.sv | 128 ++++++++++++
 tb/tb_sysid_info_regs.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/sysid_info_pkg.sv
// -----------------------------------------------------------------------------
// sysid_info_pkg
// Shared constants for the system-identification register block: data width,
// register word offsets and CTRL bit positions, plus a helper that assembles
// the CTRL readback word.
// -----------------------------------------------------------------------------
package sysid_info_pkg;

    localparam int unsigned DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    // Register word offsets
    localparam int unsigned WORD_ID        = 0;
    localparam int unsigned WORD_TIMESTAMP = 1;
    localparam int unsigned WORD_UPTIME_LO = 2;
    localparam int unsigned WORD_UPTIME_HI = 3;
    localparam int unsigned WORD_SCRATCH   = 4;
    localparam int unsigned WORD_CTRL      = 5;
    localparam int unsigned WORD_RDCOUNT   = 6;

    // Number of mapped words; everything at or above this offset is unmapped
    localparam int unsigned NUM_WORDS      = 7;

    // CTRL bit positions
    localparam int unsigned CTRL_CLEAR_BIT  = 0;
    localparam int unsigned CTRL_FREEZE_BIT = 1;

    // CTRL readback: clear is self-clearing so it always reads 0,
    // only freeze is stored.
    function automatic word_t ctrl_readback(input logic freeze);
        word_t v;
        v = '0;
        v[CTRL_FREEZE_BIT] = freeze;
        return v;
    endfunction

endpackage

// File: rtl/sysid_info_regs_if.sv
// -----------------------------------------------------------------------------
// sysid_info_regs_if
// Avalon-MM slave bundle for the sysid register block (fixed 1-cycle read
// latency, no waitrequest).
//   address       : word address, ADDR_W bits
//   read / write  : strobes
//   writedata     : 32-bit write data
//   readdata      : 32-bit registered read data
//   readdatavalid : one-cycle pulse qualifying readdata
// -----------------------------------------------------------------------------
interface sysid_info_regs_if #(
    parameter int ADDR_W = 3
) ();
    import sysid_info_pkg::*;

    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        input  readdata,
        input  readdatavalid
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        output readdata,
        output readdatavalid
    );

endinterface

// File: rtl/sysid_uptime_ctr.sv
// -----------------------------------------------------------------------------
// sysid_uptime_ctr
// Free-running uptime counter with synchronous clear, freeze and an upper-half
// snapshot register.
//   clock, reset_n : clock and asynchronous active-low reset
//   clear          : zero the counter at this edge (wins over increment)
//   freeze         : hold the counter
//   snap_take      : latch counter bits [UPTIME_W-1:32] into snap_hi
//   count_lo       : counter bits [31:0] (current, pre-increment value)
//   snap_hi        : zero-extended upper-half snapshot
// -----------------------------------------------------------------------------
module sysid_uptime_ctr
    import sysid_info_pkg::*;
#(
    parameter int UPTIME_W = 64   // legal range 33..64
) (
    input  logic  clock,
    input  logic  reset_n,
    input  logic  clear,
    input  logic  freeze,
    input  logic  snap_take,
    output word_t count_lo,
    output word_t snap_hi
);

    logic [UPTIME_W-1:0] count_reg;
    logic [UPTIME_W-1:0] count_next;
    logic [UPTIME_W-1:0] count_upper;
    word_t               snap_hi_reg;

    // Natural modulo-2^UPTIME_W wrap from the adder width.
    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (!freeze) begin
            count_next = count_reg + UPTIME_W'(1);
        end
    end

    // Upper bits shifted down; the cast below truncates to 32 bits, which
    // zero-extends for widths below 64.
    assign count_upper = count_reg >> 32;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg   <= '0;
            snap_hi_reg <= '0;
        end else begin
            count_reg <= count_next;
            // Snapshot uses the value present on the sampling edge, so LO and
            // HI of one read pair always belong to the same count.
            if (snap_take) begin
                snap_hi_reg <= word_t'(count_upper);
            end
        end
    end

    assign count_lo = count_reg[31:0];
    assign snap_hi  = snap_hi_reg;

endmodule

// File: rtl/sysid_info_regs.sv
// -----------------------------------------------------------------------------
// sysid_info_regs
// System-identification register block on an Avalon-MM slave.
// Word map: 0 ID, 1 TIMESTAMP, 2 UPTIME_LO, 3 UPTIME_HI snapshot, 4 SCRATCH,
// 5 CTRL (bit0 clear, self-clearing; bit1 freeze), 6 RDCOUNT; others read 0.
//   clock, reset_n : clock and asynchronous active-low reset
//   bus            : Avalon-MM slave (read latency 1, no waitrequest)
// A simultaneous read and write is treated as a read; the write is dropped.
// -----------------------------------------------------------------------------
module sysid_info_regs
    import sysid_info_pkg::*;
#(
    parameter word_t SYSID_ID        = 32'h6498_7102,
    parameter word_t SYSID_TIMESTAMP = 32'd0,
    parameter int    ADDR_W          = 3,    // legal range 3..8
    parameter int    UPTIME_W        = 64    // legal range 33..64
) (
    input  logic             clock,
    input  logic             reset_n,
    sysid_info_regs_if.slave bus
);

    logic [ADDR_W-1:0]    addr;
    logic [7:0]           addr_ext;
    logic                 rd_accept;
    logic                 wr_accept;
    logic [NUM_WORDS-1:0] word_hit;
    word_t                word_data [NUM_WORDS];
    word_t                rd_mux;

    logic                 ctr_clear;
    logic                 snap_take;
    word_t                count_lo;
    word_t                snap_hi;

    logic                 freeze_reg;
    word_t                scratch_reg;
    word_t                rdcount_reg;
    word_t                rdcount_next;
    word_t                readdata_reg;
    logic                 readdatavalid_reg;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    assign addr      = bus.address;
    assign addr_ext  = 8'(addr);
    assign rd_accept = bus.read;
    assign wr_accept = bus.write & ~bus.read;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_hit
            assign word_hit[gi] = (addr_ext == 8'(gi));
        end
    endgenerate

    assign ctr_clear = wr_accept & word_hit[WORD_CTRL] & bus.writedata[CTRL_CLEAR_BIT];
    assign snap_take = rd_accept & word_hit[WORD_UPTIME_LO];

    // ------------------------------------------------------------------
    // Uptime counter
    // ------------------------------------------------------------------
    sysid_uptime_ctr #(
        .UPTIME_W (UPTIME_W)
    ) u_ctr (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear     (ctr_clear),
        .freeze    (freeze_reg),
        .snap_take (snap_take),
        .count_lo  (count_lo),
        .snap_hi   (snap_hi)
    );

    // ------------------------------------------------------------------
    // Read mux: no hit (unmapped word) leaves rd_mux at zero.
    // ------------------------------------------------------------------
    assign word_data[WORD_ID]        = SYSID_ID;
    assign word_data[WORD_TIMESTAMP] = SYSID_TIMESTAMP;
    assign word_data[WORD_UPTIME_LO] = count_lo;
    assign word_data[WORD_UPTIME_HI] = snap_hi;
    assign word_data[WORD_SCRATCH]   = scratch_reg;
    assign word_data[WORD_CTRL]      = ctrl_readback(freeze_reg);
    assign word_data[WORD_RDCOUNT]   = rdcount_reg;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (word_hit[i]) begin
                rd_mux = word_data[i];
            end
        end
    end

    // Saturating read counter; a read of RDCOUNT sees the pre-increment value
    // because rd_mux samples rdcount_reg before this edge updates it.
    assign rdcount_next = (rdcount_reg == '1) ? rdcount_reg : rdcount_reg + 32'd1;

    // ------------------------------------------------------------------
    // Registers and read pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            readdata_reg      <= '0;
            readdatavalid_reg <= 1'b0;
            scratch_reg       <= '0;
            freeze_reg        <= 1'b0;
            rdcount_reg       <= '0;
        end else begin
            readdatavalid_reg <= rd_accept;
            if (rd_accept) begin
                readdata_reg <= rd_mux;
                rdcount_reg  <= rdcount_next;
            end
            if (wr_accept && word_hit[WORD_SCRATCH]) begin
                scratch_reg <= bus.writedata;
            end
            if (wr_accept && word_hit[WORD_CTRL]) begin
                freeze_reg <= bus.writedata[CTRL_FREEZE_BIT];
            end
        end
    end

    assign bus.readdata      = readdata_reg;
    assign bus.readdatavalid = readdatavalid_reg;

endmodule

// File: tb/tb_sysid_info_regs.sv
// -----------------------------------------------------------------------------
// tb_sysid_info_regs
// Directed bench for sysid_info_regs: one 64-bit-uptime instance and one
// 33-bit-uptime instance sharing clock and reset.
// -----------------------------------------------------------------------------
module tb_sysid_info_regs;
    import sysid_info_pkg::*;

    logic clock = 1'b0;
    logic reset_n;

    always #5 clock = ~clock;

    sysid_info_regs_if #(.ADDR_W(3)) bus ();
    sysid_info_regs_if #(.ADDR_W(3)) bus33 ();

    sysid_info_regs #(
        .SYSID_ID        (32'h6498_7102),
        .SYSID_TIMESTAMP (32'd0),
        .ADDR_W          (3),
        .UPTIME_W        (64)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    sysid_info_regs #(
        .SYSID_ID        (32'h6498_7102),
        .SYSID_TIMESTAMP (32'd0),
        .ADDR_W          (3),
        .UPTIME_W        (33)
    ) dut33 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus33)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_idle();
        bus.read        = 1'b0;
        bus.write       = 1'b0;
        bus.address     = '0;
        bus.writedata   = '0;
        bus33.read      = 1'b0;
        bus33.write     = 1'b0;
        bus33.address   = '0;
        bus33.writedata = '0;
    endtask

    // Drive one read on a negedge, capture the result on the next negedge.
    task automatic do_read(input bit on33, input int addr,
                           output logic [31:0] data, output logic vld);
        @(negedge clock);
        if (on33) begin
            bus33.address = 3'(addr);
            bus33.read    = 1'b1;
        end else begin
            bus.address = 3'(addr);
            bus.read    = 1'b1;
        end
        @(negedge clock);
        if (on33) begin
            bus33.read = 1'b0;
            data = bus33.readdata;
            vld  = bus33.readdatavalid;
        end else begin
            bus.read = 1'b0;
            data = bus.readdata;
            vld  = bus.readdatavalid;
        end
        $display("rd %s word %0d -> %h valid %0b", on33 ? "w33" : "w64", addr, data, vld);
    endtask

    task automatic rd_chk(input bit on33, input int addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic        v;
        do_read(on33, addr, d, v);
        chk_eq({tag, "_valid"}, 32'(v), 32'd1);
        chk_eq(tag, d, exp);
    endtask

    task automatic do_write(input int addr, input logic [31:0] data);
        @(negedge clock);
        bus.address   = 3'(addr);
        bus.writedata = data;
        bus.write     = 1'b1;
        @(negedge clock);
        bus.write = 1'b0;
        $display("wr w64 word %0d <- %h", addr, data);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] v1;
        logic        v;

        // ---------------- reset ----------------
        bus_idle();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        chk_eq("rst_valid", 32'(bus.readdatavalid), 32'd0);
        chk_eq("rst_rdata", bus.readdata, 32'd0);
        reset_n = 1'b1;

        // ---------------- ID / TIMESTAMP / RDCOUNT ----------------
        rd_chk(0, WORD_ID, 32'h6498_7102, "id");
        rd_chk(0, WORD_TIMESTAMP, 32'd0, "timestamp");
        rd_chk(0, WORD_RDCOUNT, 32'd2, "rdcount_2");
        @(negedge clock);
        chk_eq("idle_valid", 32'(bus.readdatavalid), 32'd0);
        chk_eq("idle_hold", bus.readdata, 32'd2);

        // ---------------- SCRATCH / RO / unmapped ----------------
        do_write(WORD_SCRATCH, 32'hA5A5_5A5A);
        rd_chk(0, WORD_SCRATCH, 32'hA5A5_5A5A, "scratch");
        do_write(WORD_ID, 32'h1);
        rd_chk(0, WORD_ID, 32'h6498_7102, "id_ro");
        do_write(WORD_RDCOUNT, 32'h55);
        // reads so far: 0,1,6,4,0 -> five
        rd_chk(0, WORD_RDCOUNT, 32'd5, "rdcount_ro");
        do_write(7, 32'hDEAD_BEEF);
        rd_chk(0, 7, 32'd0, "unmapped");

        // ---------------- read + write collision ----------------
        @(negedge clock);
        bus.address   = 3'(WORD_SCRATCH);
        bus.writedata = 32'h1234_5678;
        bus.read      = 1'b1;
        bus.write     = 1'b1;
        @(negedge clock);
        bus.read  = 1'b0;
        bus.write = 1'b0;
        $display("rdwr w64 word 4 -> %h valid %0b", bus.readdata, bus.readdatavalid);
        chk_eq("collide_valid", 32'(bus.readdatavalid), 32'd1);
        chk_eq("collide_old", bus.readdata, 32'hA5A5_5A5A);
        rd_chk(0, WORD_SCRATCH, 32'hA5A5_5A5A, "collide_kept");

        // ---------------- freeze / clear ----------------
        do_write(WORD_CTRL, 32'd2);
        do_read(0, WORD_UPTIME_LO, v1, v);
        repeat (10) @(negedge clock);
        rd_chk(0, WORD_UPTIME_LO, v1, "frozen_lo");
        do_write(WORD_CTRL, 32'd3);
        rd_chk(0, WORD_UPTIME_LO, 32'd0, "cleared_lo");
        rd_chk(0, WORD_CTRL, 32'd2, "ctrl_rb");
        do_write(WORD_CTRL, 32'd0);
        // frozen at 0 through the unfreeze edge, +1 on the next, read after that
        rd_chk(0, WORD_UPTIME_LO, 32'd1, "run_lo");

        // ---------------- 64-bit carry vs snapshot ----------------
        @(negedge clock);
        force dut.u_ctr.count_reg = 64'h0000_0001_FFFF_FFFF;
        bus.address = 3'(WORD_UPTIME_LO);
        bus.read    = 1'b1;
        @(negedge clock);
        bus.read = 1'b0;
        release dut.u_ctr.count_reg;
        chk_eq("carry_lo", bus.readdata, 32'hFFFF_FFFF);
        rd_chk(0, WORD_UPTIME_HI, 32'h1, "carry_hi_snap");
        do_read(0, WORD_UPTIME_LO, d, v);
        chk_eq("carry_lo_small", 32'(d < 32'd16), 32'd1);
        rd_chk(0, WORD_UPTIME_HI, 32'h2, "carry_hi_new");

        // ---------------- 33-bit wrap ----------------
        @(negedge clock);
        force dut33.u_ctr.count_reg = 33'h1_FFFF_FFFF;
        bus33.address = 3'(WORD_UPTIME_LO);
        bus33.read    = 1'b1;
        @(negedge clock);
        bus33.read = 1'b0;
        release dut33.u_ctr.count_reg;
        chk_eq("w33_lo_ones", bus33.readdata, 32'hFFFF_FFFF);
        rd_chk(1, WORD_UPTIME_HI, 32'h1, "w33_hi_before");
        do_read(1, WORD_UPTIME_LO, d, v);
        chk_eq("w33_lo_wrapped", 32'(d < 32'd16), 32'd1);
        rd_chk(1, WORD_UPTIME_HI, 32'h0, "w33_hi_wrapped");

        // ---------------- reset during read ----------------
        @(negedge clock);
        bus.address = 3'(WORD_SCRATCH);
        bus.read    = 1'b1;
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk_eq("midrst_valid", 32'(bus.readdatavalid), 32'd0);
        chk_eq("midrst_rdata", bus.readdata, 32'd0);
        bus.read = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk_eq("post_rst_valid", 32'(bus.readdatavalid), 32'd0);
        rd_chk(0, WORD_SCRATCH, 32'd0, "post_rst_scratch");
        rd_chk(0, WORD_RDCOUNT, 32'd1, "post_rst_rdcount");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
